// File: rtl/stereo_axis_pkg.sv
// Shared types and constants for the AXI-Stream line-gap synchroniser.
package stereo_axis_pkg;

    localparam int LINE_CNT_W  = 16;
    localparam int DEF_TDATA_W = 32;

    typedef enum logic {
        STREAM = 1'b0,
        GAP    = 1'b1
    } state_e;

    // Stored beat layout at the default data width: {tuser, tlast, tdata}.
    typedef struct packed {
        logic                   tuser;
        logic                   tlast;
        logic [DEF_TDATA_W-1:0] tdata;
    } axis_beat_t;

    // Width of a stored beat for an arbitrary data width.
    function automatic int beat_w(input int tdata_w);
        return tdata_w + 2;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with fall-through read data and a registered occupancy count.
module axis_sync_fifo #(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign full_o    = (cnt_q == LW'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_wr     = wr_en_i & ~full_o;
    assign do_rd     = rd_en_i & ~empty_o;
    assign rd_data_o = mem_q[rptr_q];
    assign level_o   = cnt_q;

    // Occupancy: simultaneous write and read leaves the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers and count; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Storage array, no reset needed since reads are gated by the count.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/axis_frame_gap_synch.sv
// AXI-Stream pass-through that inserts a programmable idle gap after each tlast beat.
module axis_frame_gap_synch
    import stereo_axis_pkg::*;
#(
    parameter  int AXIS_TDATA_WIDTH = 32,
    parameter  int FIFO_DEPTH       = 16,
    parameter  int MAX_GAP          = 255,
    localparam int GAP_W            = $clog2(MAX_GAP + 1),
    localparam int LVL_W            = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tuser,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    input  logic [GAP_W-1:0]            cfg_gap,
    input  logic                        cfg_bypass,
    output logic                        gap_active,
    output logic [LVL_W-1:0]            fifo_level,
    output logic [LINE_CNT_W-1:0]       line_cnt
);

    typedef struct packed {
        logic                        tuser;
        logic                        tlast;
        logic [AXIS_TDATA_WIDTH-1:0] tdata;
    } beat_t;

    localparam int BW = beat_w(AXIS_TDATA_WIDTH);

    beat_t                 wr_beat, rd_beat;
    logic                  fifo_full, fifo_empty, fifo_wr;
    state_e                state_q, state_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  vld_q, vld_d;
    beat_t                 slice_q, slice_d;
    logic [LINE_CNT_W-1:0] lcnt_q, lcnt_d;
    logic                  hs, gap_start, gap_end, load;

    // Ready follows the registered FIFO count; held low while in reset.
    assign s_axis_tready = aresetn & ~fifo_full;
    assign fifo_wr       = s_axis_tvalid & s_axis_tready;
    assign wr_beat       = '{tuser: s_axis_tuser, tlast: s_axis_tlast, tdata: s_axis_tdata};

    axis_sync_fifo #(
        .WIDTH (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .wr_en_i   (fifo_wr),
        .wr_data_i (wr_beat),
        .rd_en_i   (load),
        .rd_data_o (rd_beat),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    // Gap FSM, output-slice load decision and line counter next state.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        vld_d   = vld_q;
        slice_d = slice_q;
        lcnt_d  = lcnt_q;

        hs        = vld_q & m_axis_tready;
        gap_start = hs & slice_q.tlast & ~cfg_bypass & (cfg_gap != '0);
        // Last gap cycle (or bypass override): the slice may reload on this edge
        // so the next beat is valid right after the final idle cycle.
        gap_end   = (state_q == GAP) & (cfg_bypass | (gap_q == GAP_W'(1)));
        load      = ~fifo_empty & (~vld_q | hs) &
                    ((state_q == STREAM) ? ~gap_start : gap_end);

        case (state_q)
            STREAM: begin
                if (gap_start) begin
                    state_d = GAP;
                    gap_d   = cfg_gap;
                end
            end
            GAP: begin
                if (gap_end) begin
                    state_d = STREAM;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = STREAM;
        endcase

        if (load) begin
            vld_d   = 1'b1;
            slice_d = rd_beat;
        end else if (hs) begin
            vld_d = 1'b0;
        end

        if (hs & slice_q.tlast) lcnt_d = lcnt_q + 1'b1;
    end

    // State, gap counter, output slice and line counter registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= STREAM;
            gap_q   <= '0;
            vld_q   <= 1'b0;
            slice_q <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            vld_q   <= vld_d;
            slice_q <= slice_d;
            lcnt_q  <= lcnt_d;
        end
    end

    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = slice_q.tdata;
    assign m_axis_tlast  = slice_q.tlast;
    assign m_axis_tuser  = slice_q.tuser;
    assign gap_active    = (state_q == GAP);
    assign line_cnt      = lcnt_q;

endmodule

// File: tb/tb_axis_frame_gap_synch.sv
// Scoreboard bench: ordered beat queue plus a line/gap model driven by observed handshakes.
module tb_axis_frame_gap_synch;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int MAXG  = 255;
    localparam int GW    = $clog2(MAXG + 1);
    localparam int LW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          u;
        logic          l;
        logic [DW-1:0] d;
    } beat_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic [GW-1:0] cfg_gap = '0;
    logic          cfg_bypass = 1'b0;
    logic          gap_active;
    logic [LW-1:0] fifo_level;
    logic [15:0]   line_cnt;

    always #5 aclk = ~aclk;

    axis_frame_gap_synch #(
        .AXIS_TDATA_WIDTH (DW),
        .FIFO_DEPTH       (DEPTH),
        .MAX_GAP          (MAXG)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .cfg_gap       (cfg_gap),
        .cfg_bypass    (cfg_bypass),
        .gap_active    (gap_active),
        .fifo_level    (fifo_level),
        .line_cnt      (line_cnt)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t sb[$];
    int    gap_left = 0;
    bit    post_gap = 0;
    bit    avail_exp = 0;
    bit    prev_stall = 0;
    beat_t prev_beat;
    beat_t ob;
    int    lc_model = 0;
    int    acc_cnt = 0;
    int    rdy_mode = 0;
    int    mon_new_gap = 0;
    int    glen = 0;
    int    gap_lens[$];
    bit    t2_done = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: model says which cycles must be gap cycles and what each beat must be.
    always @(negedge aclk) begin
        if (!aresetn) begin
            sb.delete();
            gap_left   = 0;
            post_gap   = 0;
            prev_stall = 0;
            lc_model   = 0;
        end else begin
            mon_new_gap = 0;
            chk("gap_active", gap_active, gap_left > 0);
            if (gap_left > 0) chk("gap_tvalid", m_axis_tvalid, 0);
            if (post_gap) begin
                chk("post_gap_tvalid", m_axis_tvalid, avail_exp);
                post_gap = 0;
            end
            if (prev_stall) begin
                chk("hold_tvalid", m_axis_tvalid, 1);
                chk("hold_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev_beat);
            end
            chk("line_cnt", line_cnt, lc_model & 16'hFFFF);
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, 0);
                end else begin
                    ob = sb.pop_front();
                    chk("beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, ob);
                    if (ob.l) begin
                        lc_model++;
                        if (!cfg_bypass && cfg_gap != 0) mon_new_gap = int'(cfg_gap);
                    end
                end
            end
            if (gap_left > 0) begin
                if (cfg_bypass) gap_left = 0;
                else gap_left--;
                if (gap_left == 0) begin
                    post_gap  = 1;
                    avail_exp = (sb.size() > 0);
                end
            end
            if (mon_new_gap > 0) gap_left = mon_new_gap;
            if (s_axis_tvalid && s_axis_tready) begin
                sb.push_back({s_axis_tuser, s_axis_tlast, s_axis_tdata});
                acc_cnt++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        end
    end

    // Records the length of each run of gap_active cycles.
    always @(negedge aclk) begin
        if (!aresetn) glen = 0;
        else if (gap_active) glen++;
        else if (glen != 0) begin
            gap_lens.push_back(glen);
            glen = 0;
        end
    end

    // Downstream ready pattern.
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ($urandom % 4) != 0;
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    task automatic sync();
        @(posedge aclk);
        #1;
    endtask

    // Present one beat and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [DW-1:0] d, input bit l, input bit u);
        int t = 0;
        bit ok;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        do begin
            @(negedge aclk);
            ok = s_axis_tready;
            t++;
            @(posedge aclk);
            #1;
        end while (!ok && t < 2000);
        if (!ok) chk("send_timeout", 0, 1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        rdy_mode = 0;
        while ((sb.size() != 0 || gap_left != 0 || post_gap) && t < 3000) begin
            @(posedge aclk);
            t++;
        end
        chk("drain_done", t < 3000, 1);
        sync();
    endtask

    task automatic check_reset_outputs(input string tag, input bit rdy_exp);
        chk({tag, "_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_tdata"},  m_axis_tdata, 0);
        chk({tag, "_tlast"},  m_axis_tlast, 0);
        chk({tag, "_tuser"},  m_axis_tuser, 0);
        chk({tag, "_gap"},    gap_active, 0);
        chk({tag, "_level"},  fifo_level, 0);
        chk({tag, "_lcnt"},   line_cnt, 0);
        chk({tag, "_tready"}, s_axis_tready, rdy_exp);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int t;
        // Reset values.
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs("rst", 0);
        sync();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_rel_tready", s_axis_tready, 1);
        sync();

        // Two back-to-back lines with a 3-cycle gap.
        cfg_gap = 3;
        gap_lens.delete();
        for (int i = 0; i < 4; i++) send(32'h10 + i, i == 3, 0);
        for (int i = 0; i < 4; i++) send(32'h20 + i, i == 3, 0);
        drain();
        chk("t1_line_cnt", line_cnt, 2);
        chk("t1_ngaps", gap_lens.size(), 2);
        chk("t1_gap0", gap_lens[0], 3);
        chk("t1_gap1", gap_lens[1], 3);

        // Backpressure: FIFO plus slice absorb 17 beats, then ready drops.
        cfg_gap = 0;
        rdy_mode = 2;
        sync();
        sync();
        acc0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 20; i++) send(32'h200 + i, i == 19, 0);
                t2_done = 1;
            end
        join_none
        repeat (25) @(posedge aclk);
        @(negedge aclk);
        chk("t2_accepted", acc_cnt - acc0, 17);
        chk("t2_level", fifo_level, 16);
        chk("t2_tready", s_axis_tready, 0);
        chk("t2_head_valid", m_axis_tvalid, 1);
        chk("t2_head_data", m_axis_tdata, 32'h200);
        sync();
        rdy_mode = 0;
        t = 0;
        while (!t2_done && t < 500) begin
            @(posedge aclk);
            t++;
        end
        chk("t2_done", t2_done, 1);
        sync();
        drain();

        // Zero gap, then bypass with a nonzero gap: no gap cycles at all.
        gap_lens.delete();
        cfg_gap = 0;
        for (int i = 0; i < 6; i++) send(32'h300 + i, (i % 3) == 2, 0);
        cfg_bypass = 1;
        cfg_gap = 5;
        for (int i = 0; i < 6; i++) send(32'h310 + i, (i % 3) == 2, 0);
        drain();
        chk("t3_no_gaps", gap_lens.size() + glen, 0);
        cfg_bypass = 0;

        // tuser on first beat only; gap of 2 after tlast.
        gap_lens.delete();
        cfg_gap = 2;
        for (int i = 0; i < 4; i++) send(32'hA0 + i, i == 3, i == 0);
        for (int i = 0; i < 4; i++) send(32'hB0 + i, i == 3, 0);
        drain();
        chk("t4_gap0", gap_lens[0], 2);
        chk("t4_gap1", gap_lens[1], 2);

        // Reset mid-gap with 8 beats buffered.
        cfg_gap = 200;
        for (int i = 0; i < 4; i++) send(32'h50 + i, i == 3, 0);
        for (int i = 0; i < 8; i++) send(32'h60 + i, 0, 0);
        @(negedge aclk);
        chk("t5_gap_before", gap_active, 1);
        chk("t5_level_before", fifo_level, 8);
        sync();
        aresetn = 1'b0;
        sync();
        aresetn = 1'b1;
        cfg_gap = 0;
        @(negedge aclk);
        check_reset_outputs("t5", 1);
        repeat (5) @(posedge aclk);
        @(negedge aclk);
        chk("t5_no_gap", gap_active, 0);
        chk("t5_empty_out", m_axis_tvalid, 0);
        sync();

        // Gap value change mid-gap affects only the following line.
        gap_lens.delete();
        cfg_gap = 4;
        for (int i = 0; i < 3; i++) send(32'h70 + i, i == 2, 0);
        t = 0;
        while (!gap_active && t < 50) begin
            @(negedge aclk);
            t++;
        end
        chk("t6_gap_seen", gap_active, 1);
        sync();
        cfg_gap = 1;
        for (int i = 0; i < 3; i++) send(32'h80 + i, i == 2, 0);
        for (int i = 0; i < 3; i++) send(32'h90 + i, i == 2, 0);
        drain();
        chk("t6_gap0", gap_lens[0], 4);
        chk("t6_gap1", gap_lens[1], 1);
        chk("t6_gap2", gap_lens[2], 1);

        // Randomised traffic against the model.
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 8 == 0) cfg_gap = GW'($urandom_range(0, 6));
            if ($urandom % 10 == 0) cfg_bypass = ($urandom % 4) == 0;
            if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) sync();
            send($urandom, ($urandom % 5) == 0, ($urandom % 7) == 0);
        end
        drain();
        cfg_bypass = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
